melody_sequencer: RTL and testbench
===================================

MELODY_SEQUENCER -- requirements
Module: melody_sequencer

Interface
REQ-001 Parameter NUM_NOTES, default 16: number of note-table entries, indices 0..NUM_NOTES-1.
REQ-002 Parameter TICK_DIV, default 50000: clk cycles per duration tick (1 ms at 50 MHz).
REQ-003 Parameter GAP_TICKS, default 20: silent ticks inserted after every note.
REQ-004 Port clk  in  1  single system clock; all logic on rising edge.
REQ-005 Port rst_n  in  1  reset, asynchronous assert, active-low.
REQ-006 Port start  in  1  one-cycle request to begin playback from entry 0.
REQ-007 Port stop  in  1  abort playback.
REQ-008 Port loop  in  1  level; when high, playback restarts at entry 0 instead of finishing.
REQ-009 Port wr_en  in  1  note-table write strobe.
REQ-010 Port wr_addr  in  4  table index written.
REQ-011 Port wr_div  in  15  half-period divider; 0 = rest.
REQ-012 Port wr_dur  in  10  note length in ticks; 0 = end-of-sequence marker.
REQ-013 Port speaker  out  1  square-wave tone output, registered.
REQ-014 Port busy  out  1  high in PLAY or GAP.
REQ-015 Port note_idx  out  4  index of the entry being played.
REQ-016 Port done  out  1  one-cycle pulse on normal completion.

Function
REQ-017 States: IDLE, PLAY, GAP; busy SHALL be 1 exactly when state is not IDLE.
REQ-018 In IDLE, when wr_en=1 and wr_addr<NUM_NOTES, the entry SHALL be updated at that edge; writes with wr_addr>=NUM_NOTES and all writes while busy=1 SHALL be ignored.
REQ-019 When start=1 in IDLE and entry 0 dur!=0, state SHALL be PLAY from the next cycle with note_idx=0, the tone counter and tick counter cleared, and speaker=0.
REQ-020 A write and a start in the same IDLE cycle SHALL both take effect; playback SHALL use the updated table.
REQ-021 When start=1 in IDLE and entry 0 dur=0, state SHALL remain IDLE and done SHALL pulse the next cycle.
REQ-022 start while busy=1 SHALL be ignored.
REQ-023 In PLAY with div!=0, the tone counter SHALL count 0..div, toggling speaker and wrapping to 0 when it equals div, giving a half-period of div+1 cycles.
REQ-024 In PLAY with div=0, speaker SHALL be held 0 (rest).
REQ-025 PLAY SHALL last exactly dur*TICK_DIV cycles, then enter GAP.
REQ-026 In GAP, speaker SHALL be 0 and GAP SHALL last exactly GAP_TICKS*TICK_DIV cycles; with GAP_TICKS=0, GAP SHALL be skipped.
REQ-027 At the end of GAP: if note_idx=NUM_NOTES-1 or entry note_idx+1 has dur=0, the sequence ends; otherwise note_idx SHALL increment, and PLAY SHALL restart with counters cleared and speaker=0.
REQ-028 At sequence end with loop=1 (sampled that cycle), note_idx SHALL return to 0 in PLAY with no done pulse.
REQ-029 At sequence end with loop=0, state SHALL become IDLE and done SHALL be 1 for that single cycle.
REQ-030 stop=1 in any state SHALL force IDLE, speaker=0, and note_idx=0 next cycle, with no done pulse; stop wins over start in the same cycle.
REQ-031 note_idx SHALL hold its value during GAP and SHALL be 0 in IDLE.

Reset
REQ-032 rst_n=0 SHALL immediately force state IDLE, speaker=0, busy=0, done=0, note_idx=0, clear all counters, and set every table entry to div=0, dur=0.
REQ-033 Reset asserted mid-playback SHALL abort without a done pulse; after release, the block SHALL stay idle until start.

Verification (TICK_DIV=4, GAP_TICKS=1, NUM_NOTES=4)
REQ-034 Write e0 div=1 dur=2 and e1 dur=0, then start -> speaker toggles every 2 cycles for 8 cycles (4 toggles), 0 for 4 cycles, then done=1 for 1 cycle and busy=0.
REQ-035 Write e0 div=0 dur=1 and e1 dur=0, then start -> speaker stays 0 for 4 PLAY cycles and 4 GAP cycles, then done pulses.
REQ-036 Write 4 entries each with dur=1, hold loop=1 -> note_idx steps 0,1,2,3,0,1 every 8 cycles with no done; drop loop -> after idx 3 completes, done pulses once.
REQ-037 Assert stop mid-note with wr_en to e0 in the same busy window -> next cycle busy=0, speaker=0, note_idx=0, no done; the next playback uses the old e0.
REQ-038 start directly after reset -> done pulses 1 cycle later and busy never rises.
REQ-039 Pull rst_n low mid-PLAY while speaker=1 -> speaker, busy, and note_idx go to 0 without waiting for a clk edge.

Source files
------------

// File: rtl/melody_sequencer.sv
// Note-table melody player: each entry is a tone (half-period divider) held for a number of
// ticks, followed by a fixed silent gap. Playback can loop, and it can be stopped at any time.
module melody_sequencer #(
  parameter int unsigned NUM_NOTES = 16,
  parameter int unsigned TICK_DIV  = 50000,
  parameter int unsigned GAP_TICKS = 20
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic        stop,
  input  logic        loop,
  input  logic        wr_en,
  input  logic [3:0]  wr_addr,
  input  logic [14:0] wr_div,
  input  logic [9:0]  wr_dur,
  output logic        speaker,
  output logic        busy,
  output logic [3:0]  note_idx,
  output logic        done
);

  localparam int unsigned IdxW  = (NUM_NOTES > 1) ? $clog2(NUM_NOTES) : 1;
  localparam int unsigned TickW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

  localparam logic [TickW-1:0] TickLast  = TickW'(TICK_DIV - 1);
  localparam logic [15:0]      GapLast   = 16'(GAP_TICKS - 1);
  localparam logic [3:0]       IdxLast   = 4'(NUM_NOTES - 1);
  localparam logic [4:0]       NumNotes5 = 5'(NUM_NOTES);

  typedef enum logic [1:0] {StIdle, StPlay, StGap} state_e;

  state_e            state_q, state_d;
  logic [14:0]       div_q [NUM_NOTES];
  logic [9:0]        dur_q [NUM_NOTES];
  logic [3:0]        idx_q, idx_d;
  logic [14:0]       tone_q, tone_d;
  logic [TickW-1:0]  tick_q, tick_d;
  logic [15:0]       cnt_q, cnt_d;
  logic              spk_q, spk_d;
  logic              done_q, done_d;

  logic [IdxW-1:0]   rd_idx, nxt_rd_idx;
  logic [14:0]       cur_div;
  logic [9:0]        cur_dur;
  logic [9:0]        start_dur;
  logic              wr_ok, tick_last, play_end, gap_end, note_end, last_note;

  assign rd_idx     = idx_q[IdxW-1:0];
  assign nxt_rd_idx = rd_idx + IdxW'(1);
  assign cur_div    = div_q[rd_idx];
  assign cur_dur    = dur_q[rd_idx];
  assign last_note  = (idx_q == IdxLast) || (dur_q[nxt_rd_idx] == '0);

  // A write to entry 0 in the start cycle must be seen by the start decision.
  assign start_dur = (wr_en && (wr_addr == 4'd0)) ? wr_dur : dur_q[0];
  assign wr_ok     = wr_en && (state_q == StIdle) && ({1'b0, wr_addr} < NumNotes5);

  assign tick_last = (tick_q == TickLast);
  assign play_end  = (state_q == StPlay) && tick_last && (cnt_q == 16'(cur_dur) - 16'd1);
  assign gap_end   = (state_q == StGap) && tick_last && (cnt_q == GapLast);
  assign note_end  = (GAP_TICKS == 0) ? play_end : gap_end;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < int'(NUM_NOTES); i++) begin
        div_q[i] <= '0;
        dur_q[i] <= '0;
      end
    end else if (wr_ok) begin
      div_q[wr_addr[IdxW-1:0]] <= wr_div;
      dur_q[wr_addr[IdxW-1:0]] <= wr_dur;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      StIdle: if (start && (start_dur != '0)) state_d = StPlay;
      StPlay: begin
        if (play_end) begin
          if (GAP_TICKS != 0)           state_d = StGap;
          else if (last_note && !loop) state_d = StIdle;
        end
      end
      StGap: begin
        if (gap_end) state_d = (last_note && !loop) ? StIdle : StPlay;
      end
      default: state_d = StIdle;
    endcase
    if (stop) state_d = StIdle;
  end

  always_comb begin
    idx_d  = idx_q;
    tone_d = tone_q;
    tick_d = tick_q;
    cnt_d  = cnt_q;
    spk_d  = spk_q;
    done_d = 1'b0;
    if (stop || (state_q == StIdle)) begin
      idx_d  = '0;
      tone_d = '0;
      tick_d = '0;
      cnt_d  = '0;
      spk_d  = 1'b0;
      done_d = !stop && (state_q == StIdle) && start && (start_dur == '0);
    end else if (note_end || play_end) begin
      tone_d = '0;
      tick_d = '0;
      cnt_d  = '0;
      spk_d  = 1'b0;
      if (note_end) begin
        if (!last_note) begin
          idx_d = idx_q + 4'd1;
        end else begin
          idx_d  = '0;
          done_d = !loop;
        end
      end
    end else begin
      if (tick_last) begin
        tick_d = '0;
        cnt_d  = cnt_q + 16'd1;
      end else begin
        tick_d = tick_q + TickW'(1);
      end
      if ((state_q == StPlay) && (cur_div != '0)) begin
        if (tone_q == cur_div) begin
          tone_d = '0;
          spk_d  = !spk_q;
        end else begin
          tone_d = tone_q + 15'd1;
        end
      end else begin
        tone_d = '0;
        spk_d  = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idx_q  <= '0;
      tone_q <= '0;
      tick_q <= '0;
      cnt_q  <= '0;
      spk_q  <= 1'b0;
      done_q <= 1'b0;
    end else begin
      idx_q  <= idx_d;
      tone_q <= tone_d;
      tick_q <= tick_d;
      cnt_q  <= cnt_d;
      spk_q  <= spk_d;
      done_q <= done_d;
    end
  end

  assign speaker  = spk_q;
  assign busy     = (state_q != StIdle);
  assign note_idx = idx_q;
  assign done     = done_q;

endmodule

// File: tb/tb_melody_sequencer.sv
// Directed bench for melody_sequencer with a small table and short ticks.
module tb_melody_sequencer;

  logic        clk     = 1'b0;
  logic        rst_n   = 1'b0;
  logic        start   = 1'b0;
  logic        stop    = 1'b0;
  logic        loop    = 1'b0;
  logic        wr_en   = 1'b0;
  logic [3:0]  wr_addr = '0;
  logic [14:0] wr_div  = '0;
  logic [9:0]  wr_dur  = '0;
  logic        speaker, busy, done;
  logic [3:0]  note_idx;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  melody_sequencer #(
    .NUM_NOTES(4),
    .TICK_DIV (4),
    .GAP_TICKS(1)
  ) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .start   (start),
    .stop    (stop),
    .loop    (loop),
    .wr_en   (wr_en),
    .wr_addr (wr_addr),
    .wr_div  (wr_div),
    .wr_dur  (wr_dur),
    .speaker (speaker),
    .busy    (busy),
    .note_idx(note_idx),
    .done    (done)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic step_n(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic wr(input logic [3:0] a, input logic [14:0] d, input logic [9:0] u);
    wr_en   = 1'b1;
    wr_addr = a;
    wr_div  = d;
    wr_dur  = u;
    step();
    wr_en   = 1'b0;
  endtask

  initial begin
    // Reset state
    #3;
    check("rst_speaker", speaker, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_idx", note_idx, 0);
    step();
    step();
    rst_n = 1'b1;
    step();
    check("idle_busy", busy, 0);

    // Start with an empty table: immediate done, never busy
    start = 1'b1;
    step();
    start = 1'b0;
    check("empty_done", done, 1);
    check("empty_busy", busy, 0);
    step();
    check("empty_done_clr", done, 0);
    check("empty_busy2", busy, 0);

    // Single note div=1 dur=2: toggles every 2 cycles for 8, then 4 silent, then done
    wr(4'd0, 15'd1, 10'd2);
    wr(4'd1, 15'd0, 10'd0);
    start = 1'b1;
    step();
    start = 1'b0;
    check("tone_idx", note_idx, 0);
    for (int i = 0; i < 8; i++) begin
      check("tone_spk", speaker, (i / 2) % 2);
      check("tone_busy", busy, 1);
      check("tone_done", done, 0);
      step();
    end
    for (int i = 0; i < 4; i++) begin
      check("gap_spk", speaker, 0);
      check("gap_busy", busy, 1);
      check("gap_done", done, 0);
      step();
    end
    check("tone_end_done", done, 1);
    check("tone_end_busy", busy, 0);
    step();
    check("tone_end_done_clr", done, 0);

    // Rest note written in the same cycle as start
    wr_en   = 1'b1;
    wr_addr = 4'd0;
    wr_div  = 15'd0;
    wr_dur  = 10'd1;
    start   = 1'b1;
    step();
    wr_en   = 1'b0;
    start   = 1'b0;
    for (int i = 0; i < 8; i++) begin
      check("rest_spk", speaker, 0);
      check("rest_busy", busy, 1);
      step();
    end
    check("rest_done", done, 1);
    step();

    // Looping over four one-tick notes, then drop loop
    for (int a = 0; a < 4; a++) wr(4'(a), 15'd2, 10'd1);
    loop  = 1'b1;
    start = 1'b1;
    step();
    start = 1'b0;
    for (int k = 0; k < 48; k++) begin
      check("loop_idx", note_idx, (k / 8) % 4);
      check("loop_busy", busy, 1);
      check("loop_done", done, 0);
      step();
    end
    loop = 1'b0;
    for (int k = 0; k < 16; k++) begin
      check("unloop_idx", note_idx, 2 + k / 8);
      check("unloop_done", done, 0);
      step();
    end
    check("unloop_end_done", done, 1);
    check("unloop_end_busy", busy, 0);
    check("unloop_end_idx", note_idx, 0);
    step();
    check("unloop_done_clr", done, 0);

    // Write while busy is dropped; stop mid-note with start held
    start = 1'b1;
    step();
    start   = 1'b0;
    wr_en   = 1'b1;
    wr_addr = 4'd0;
    wr_div  = 15'd0;
    wr_dur  = 10'd0;
    step();
    wr_en = 1'b0;
    step_n(10);
    check("pre_stop_idx", note_idx, 1);
    check("pre_stop_spk", speaker, 1);
    stop  = 1'b1;
    start = 1'b1;
    step();
    check("stop_busy", busy, 0);
    check("stop_spk", speaker, 0);
    check("stop_idx", note_idx, 0);
    check("stop_done", done, 0);
    step();
    check("stop_wins_busy", busy, 0);
    check("stop_wins_done", done, 0);
    stop = 1'b0;
    step();
    start = 1'b0;
    check("old_e0_busy", busy, 1);
    check("old_e0_idx", note_idx, 0);
    stop = 1'b1;
    step();
    stop = 1'b0;
    check("stop2_busy", busy, 0);

    // Asynchronous reset while the speaker is high
    start = 1'b1;
    step();
    start = 1'b0;
    step_n(11);
    check("pre_rst_idx", note_idx, 1);
    check("pre_rst_spk", speaker, 1);
    #2;
    rst_n = 1'b0;
    #1;
    check("async_rst_spk", speaker, 0);
    check("async_rst_busy", busy, 0);
    check("async_rst_idx", note_idx, 0);
    check("async_rst_done", done, 0);
    step();
    rst_n = 1'b1;
    step_n(3);
    check("post_rst_busy", busy, 0);
    check("post_rst_nodone", done, 0);

    // Table was cleared by reset
    start = 1'b1;
    step();
    start = 1'b0;
    check("cleared_done", done, 1);
    check("cleared_busy", busy, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
